aes128_enc_arbiter: RTL and testbench
=====================================

AES128_ENC_ARBITER -- requirements
Module: aes128_enc_arbiter

Interface
REQ-001 SHALL have parameter CORE_LATENCY, default 10, meaning the number of CLK cycles from operands stable at the core inputs to a valid opRetValue; legal range 1..255.
REQ-002 SHALL have port CLK  input  1  the single clock for all state.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req0 / req1  input  1 each  requester N has a block pending.
REQ-005 SHALL have port data0 / data1  input  128 each  plaintext from requester N.
REQ-006 SHALL have port key0 / key1  input  128 each  key from requester N.
REQ-007 SHALL have port ack0 / ack1  output  1 each  one-cycle pulse: requester N's operands have been captured.
REQ-008 SHALL have port encEnable  output  1  drives the encrypt core enable.
REQ-009 SHALL have port dataToOperate / keyToOperate  output  128 each  registered operands to the core.
REQ-010 SHALL have port opRetValue  input  128  ciphertext returned by the core.
REQ-011 SHALL have port resValid  output  1  result is held for the consumer.
REQ-012 SHALL have port resReady  input  1  consumer accepts the result.
REQ-013 SHALL have port resData / resId  output  128 / 1  ciphertext and the index of the requester that issued it.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and HOLD.
REQ-015 IDLE SHALL work as follows: if req0|req1 is set at a rising edge, capture the granted data/key into dataToOperate/keyToOperate, latch resId, pulse ackN the following cycle, load the counter with CORE_LATENCY and go to RUN; otherwise stay in IDLE.
REQ-016 Grant SHALL follow these rules: a single request is granted; if both are set, grant rrPtr; after each result is accepted, rrPtr SHALL point to the requester not just served.
REQ-017 RUN SHALL hold encEnable=1, hold the operands stable and decrement the counter each cycle; when the counter equals 1, capture opRetValue into resData, set resValid=1 and go to HOLD.
REQ-018 Latency SHALL be fixed: resValid rises exactly CORE_LATENCY+1 cycles after the accepting edge.
REQ-019 HOLD SHALL keep encEnable=0 and keep resData/resId stable while resValid=1 and resReady=0 (backpressure is unbounded); resValid&resReady SHALL complete the transfer, clear resValid and return to IDLE.
REQ-020 No new request SHALL be accepted in RUN or HOLD; at most one operation is in flight.
REQ-021 Requesters SHALL hold reqN and their operands until ackN; a req dropped before ack is not served and leaves no side effect.
REQ-022 The counter SHALL be $clog2(CORE_LATENCY+1) bits wide, SHALL never wrap and SHALL never be loaded with 0.

Reset
REQ-023 RST=1 at an edge SHALL force IDLE and set rrPtr=0, ack0=ack1=0, encEnable=0, resValid=0, resId=0, resData=0, dataToOperate=0, keyToOperate=0 and counter=0.
REQ-024 Reset during RUN or HOLD SHALL abort the operation silently, with no resValid and no ack.
REQ-025 RST SHALL take priority over every simultaneous request or handshake.

Configuration
REQ-026 Macro AES128_ARB_STATS_EN, when defined, SHALL add output ports opCount0 / opCount1 (32 bits each), which increment on each accepted result per resId, saturate at 32'hFFFFFFFF and reset to 0.
REQ-027 When AES128_ARB_STATS_EN is undefined, those ports and counters SHALL be absent, with no other change in behaviour.

Structure
REQ-028 Package aes128_pkg SHALL hold the FSM state typedef (IDLE/RUN/HOLD), AES128_BLOCK_W=128 and AES128_DEFAULT_LATENCY=10.
REQ-029 Sub-module aes128_rr_arb SHALL contain the 2-way round-robin grant logic and rrPtr update; the FSM and datapath registers stay in the top.

Verification
REQ-030 Scenario 1: req0 with key 000102030405060708090a0b0c0d0e0f and data 00112233445566778899aabbccddeeff against a real core, resReady=1 -> resData=69c4e0d86a7b0430d8cdb78070b4c55a, resId=0, resValid at acceptance+11.
REQ-031 Scenario 2: req0 and req1 asserted on the same edge after reset -> req0 served first, then req1; ack order 0,1; resId order 0,1.
REQ-032 Scenario 3: req1 held continuously with req0 pulsed repeatedly -> grants alternate and neither requester is starved.
REQ-033 Scenario 4: resReady=0 for 20 cycles -> resValid and resData stay stable, ack0/ack1 stay 0 and encEnable stays 0; one cycle of resReady -> IDLE.
REQ-034 Scenario 5: RST asserted 4 cycles into RUN -> all outputs at reset values the next cycle and no resValid for that operation.
REQ-035 Scenario 6: with AES128_ARB_STATS_EN defined and 3 results for requester 0 plus 2 for requester 1 -> opCount0=3 and opCount1=2.

Source files
------------

// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared types and constants for the AES-128 encrypt arbiter
package aes128_pkg;

  localparam int AES128_BLOCK_W         = 128;
  localparam int AES128_DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } aesState_t;

endpackage

// File: rtl/aes128_rr_arb.sv
// rtl/aes128_rr_arb.sv - two-way round-robin grant with pointer update on result acceptance
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req0, req1          pending requests
//   servedValid         a result was accepted by the consumer this cycle
//   servedId            requester whose result was accepted
//   grantValid          at least one request is pending
//   grantId             requester that wins this cycle
//   rrPtr               preferred requester when both are pending
module aes128_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic servedValid,
  input  logic servedId,
  output logic grantValid,
  output logic grantId,
  output logic rrPtr
);

  always_comb begin
    grantValid = req0 | req1;
    // A lone request wins outright; a tie goes to the pointer.
    grantId    = (req0 && req1) ? rrPtr : req1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr <= 1'b0;
    end else if (servedValid) begin
      rrPtr <= ~servedId;
    end
  end

endmodule

// File: rtl/aes128_enc_arbiter.sv
// rtl/aes128_enc_arbiter.sv - arbitrates two requesters onto one fixed-latency AES-128 encrypt core
//
// Optional feature macro: AES128_ARB_STATS_EN adds per-requester result counters.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   req0/req1, data0/data1,     requester handshake and operands; held until ackN
//   key0/key1, ack0/ack1
//   encEnable                   core enable, high while an operation runs
//   dataToOperate/keyToOperate  registered operands to the core
//   opRetValue                  ciphertext from the core
//   resValid/resReady           result handshake toward the consumer
//   resData/resId               ciphertext and issuing requester
//   opCount0/opCount1           saturating accepted-result counters (stats build only)
module aes128_enc_arbiter
  import aes128_pkg::*;
#(
  parameter int CORE_LATENCY = AES128_DEFAULT_LATENCY
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      req0,
  input  logic                      req1,
  input  logic [AES128_BLOCK_W-1:0] data0,
  input  logic [AES128_BLOCK_W-1:0] data1,
  input  logic [AES128_BLOCK_W-1:0] key0,
  input  logic [AES128_BLOCK_W-1:0] key1,
  output logic                      ack0,
  output logic                      ack1,
  output logic                      encEnable,
  output logic [AES128_BLOCK_W-1:0] dataToOperate,
  output logic [AES128_BLOCK_W-1:0] keyToOperate,
  input  logic [AES128_BLOCK_W-1:0] opRetValue,
  output logic                      resValid,
  input  logic                      resReady,
  output logic [AES128_BLOCK_W-1:0] resData,
  output logic                      resId
`ifdef AES128_ARB_STATS_EN
  ,
  output logic [31:0]               opCount0,
  output logic [31:0]               opCount1
`endif
);

  localparam int CNT_W = $clog2(CORE_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  aesState_t        state;
  aesState_t        nextState;
  logic [CNT_W-1:0] counter;
  logic             coreStarted;
  logic             accept;
  logic             capture;
  logic             handshake;
  logic             grantValid;
  logic             grantId;
  logic             rrPtr;

  aes128_rr_arb uArb (
    .clk         (CLK),
    .rst         (RST),
    .req0        (req0),
    .req1        (req1),
    .servedValid (handshake),
    .servedId    (resId),
    .grantValid  (grantValid),
    .grantId     (grantId),
    .rrPtr       (rrPtr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    encEnable = 1'b0;
    resValid  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (grantValid) begin
          accept    = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        encEnable = 1'b1;
        if (coreStarted && (counter == CNT_ONE)) begin
          capture   = 1'b1;
          nextState = HOLD;
        end
      end
      HOLD: begin
        resValid = 1'b1;
        if (resReady) begin
          handshake = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // The core first samples the registered operands on the edge after
  // acceptance, so the countdown starts one cycle later; this puts resValid
  // CORE_LATENCY+1 cycles after the accepting edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      dataToOperate <= '0;
      keyToOperate  <= '0;
      resData       <= '0;
      resId         <= 1'b0;
      counter       <= '0;
      coreStarted   <= 1'b0;
    end else begin
      ack0 <= accept && !grantId;
      ack1 <= accept && grantId;
      if (accept) begin
        dataToOperate <= grantId ? data1 : data0;
        keyToOperate  <= grantId ? key1 : key0;
        resId         <= grantId;
        counter       <= CNT_LOAD;
        coreStarted   <= 1'b0;
      end else if (state == RUN) begin
        coreStarted <= 1'b1;
        if (coreStarted) begin
          counter <= counter - CNT_ONE;
        end
      end
      if (capture) begin
        resData <= opRetValue;
      end
    end
  end

`ifdef AES128_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      opCount0 <= '0;
      opCount1 <= '0;
    end else if (handshake) begin
      if (!resId && (opCount0 != '1)) opCount0 <= opCount0 + 32'd1;
      if (resId && (opCount1 != '1)) opCount1 <= opCount1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes128_enc_arbiter.sv
// tb/tb_aes128_enc_arbiter.sv - scoreboard bench for the AES-128 encrypt arbiter
module tb_aes128_enc_arbiter;

  localparam int LAT = 10;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK     = {4{32'hDEADBEEF}};

  logic         CLK = 1'b0;
  logic         RST;
  logic         req0, req1;
  logic [127:0] data0, data1, key0, key1;
  logic         ack0, ack1;
  logic         encEnable;
  logic [127:0] dataToOperate, keyToOperate;
  logic [127:0] opRetValue;
  logic         resValid;
  logic         resReady;
  logic [127:0] resData;
  logic         resId;
`ifdef AES128_ARB_STATS_EN
  logic [31:0]  opCount0, opCount1;
`endif

  always #5 CLK = ~CLK;

  aes128_enc_arbiter #(.CORE_LATENCY(LAT)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req0          (req0),
    .req1          (req1),
    .data0         (data0),
    .data1         (data1),
    .key0          (key0),
    .key1          (key1),
    .ack0          (ack0),
    .ack1          (ack1),
    .encEnable     (encEnable),
    .dataToOperate (dataToOperate),
    .keyToOperate  (keyToOperate),
    .opRetValue    (opRetValue),
    .resValid      (resValid),
    .resReady      (resReady),
    .resData       (resData),
    .resId         (resId)
`ifdef AES128_ARB_STATS_EN
    ,
    .opCount0      (opCount0),
    .opCount1      (opCount1)
`endif
  );

  // Stand-in core: the FIPS-197 vector is answered exactly, anything else gets
  // a keyed mix; the answer appears only once encEnable has been high LAT edges.
  function automatic logic [127:0] coreFn(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return d ^ {k[63:0], k[127:64]} ^ {4{32'hA5C35A3C}};
  endfunction

  function automatic logic [127:0] mkData(input int i);
    return {32'h00112233 + 32'(i), 32'h44556677, 32'h8899aabb ^ 32'(i * 3), 32'hccddeeff};
  endfunction

  function automatic logic [127:0] mkKey(input int i);
    return {32'h0f0e0d0c, 32'(i) * 32'h01010101, 32'h07060504, 32'h03020100};
  endfunction

  int coreCnt = 0;
  always @(posedge CLK) coreCnt <= encEnable ? coreCnt + 1 : 0;
  assign opRetValue = (coreCnt >= LAT) ? coreFn(dataToOperate, keyToOperate) : JUNK;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
    logic [127:0] key;
  } ackExp_t;

  typedef struct packed {
    logic         id;
    logic [127:0] res;
  } resExp_t;

  ackExp_t ackQ[$];
  resExp_t resQ[$];
  int applied = 0;
  int miscompares = 0;
  int cycle = 0;
  int ackCycle = 0;
  logic prevValid = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expectOp(input logic id, input logic [127:0] d, input logic [127:0] k, input logic [127:0] r);
    ackQ.push_back('{id: id, data: d, key: k});
    resQ.push_back('{id: id, res: r});
  endtask

  // Monitor: pops expectations whenever the DUT acks or hands over a result.
  always @(negedge CLK) begin
    ackExp_t ae;
    resExp_t re;
    cycle++;
    if (ack0 || ack1) begin
      check("ack_exclusive", 128'(ack0 & ack1), 128'(0));
      if (ackQ.size() == 0) begin
        check("ack_unexpected", 128'({ack1, ack0}), 128'(0));
      end else begin
        ae = ackQ.pop_front();
        check("ack_id", 128'(ack1), 128'(ae.id));
        check("operand_data", dataToOperate, ae.data);
        check("operand_key", keyToOperate, ae.key);
      end
      ackCycle = cycle;
    end
    if (resValid && !prevValid) check("latency", 128'(cycle - ackCycle), 128'(LAT + 1));
    if (resValid && resReady) begin
      if (resQ.size() == 0) begin
        check("result_unexpected", 128'(resValid), 128'(0));
      end else begin
        re = resQ.pop_front();
        check("res_id", 128'(resId), 128'(re.id));
        check("res_data", resData, re.res);
      end
    end
    prevValid = resValid;
  end

  task automatic request(input logic id, input logic [127:0] d, input logic [127:0] k);
    int n;
    n = 0;
    if (id) begin data1 = d; key1 = k; req1 = 1'b1; end
    else begin data0 = d; key0 = k; req0 = 1'b1; end
    do begin @(negedge CLK); n++; end while (((id && !ack1) || (!id && !ack0)) && n < 200);
    if (n >= 200) check("ack_timeout", 128'(0), 128'(1));
    if (id) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resQ.size() != 0 || resValid) && n < 500) begin @(negedge CLK); n++; end
    if (n >= 500) check("drain_timeout", 128'(resQ.size()), 128'(0));
    @(negedge CLK);
  endtask

  task automatic doReset();
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] held;
    int n;
    RST = 1'b1; req0 = 1'b0; req1 = 1'b0; resReady = 1'b1;
    data0 = '0; data1 = '0; key0 = '0; key1 = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_flags", 128'({ack0, ack1, encEnable, resValid, resId}), 128'(0));
    check("reset_resData", resData, 128'(0));
    check("reset_operands", dataToOperate | keyToOperate, 128'(0));

    // FIPS-197 vector through requester 0
    expectOp(1'b0, FIPS_PT, FIPS_KEY, FIPS_CT);
    request(1'b0, FIPS_PT, FIPS_KEY);
    drain();

    // simultaneous requests straight after reset: 0 first, then 1
    doReset();
    expectOp(1'b0, mkData(1), mkKey(1), coreFn(mkData(1), mkKey(1)));
    expectOp(1'b1, mkData(2), mkKey(2), coreFn(mkData(2), mkKey(2)));
    fork
      request(1'b0, mkData(1), mkKey(1));
      request(1'b1, mkData(2), mkKey(2));
    join
    drain();

    // req1 held continuously, req0 pulsed three times: 0,1,0,1,0,1,1
    doReset();
    for (int i = 0; i < 3; i++) begin
      expectOp(1'b0, mkData(10 + i), mkKey(10 + i), coreFn(mkData(10 + i), mkKey(10 + i)));
      expectOp(1'b1, mkData(20 + i), mkKey(20 + i), coreFn(mkData(20 + i), mkKey(20 + i)));
    end
    expectOp(1'b1, mkData(23), mkKey(23), coreFn(mkData(23), mkKey(23)));
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          request(1'b0, mkData(10 + i), mkKey(10 + i));
          repeat (2) @(negedge CLK);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          int m;
          m = 0;
          data1 = mkData(20 + i); key1 = mkKey(20 + i); req1 = 1'b1;
          do begin @(negedge CLK); m++; end while (!ack1 && m < 200);
          if (m >= 200) check("ack1_timeout", 128'(0), 128'(1));
        end
        req1 = 1'b0;
      end
    join
    drain();

    // backpressure for 20 cycles
    resReady = 1'b0;
    expectOp(1'b1, mkData(30), mkKey(30), coreFn(mkData(30), mkKey(30)));
    request(1'b1, mkData(30), mkKey(30));
    n = 0;
    do begin @(negedge CLK); n++; end while (!resValid && n < 100);
    if (n >= 100) check("resValid_timeout", 128'(0), 128'(1));
    held = resData;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("bp_flags", 128'({resValid, ack0, ack1, encEnable}), 128'(4'b1000));
      check("bp_resData", resData, held);
    end
    @(posedge CLK); #1 resReady = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_released", 128'({resValid, encEnable}), 128'(0));

    // reset four cycles into RUN, with a competing request at the reset edge
    ackQ.push_back('{id: 1'b0, data: mkData(40), key: mkKey(40)});
    request(1'b0, mkData(40), mkKey(40));
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1; req0 = 1'b1;
    @(posedge CLK); #1;
    check("abort_flags", 128'({ack0, ack1, encEnable, resValid, resId}), 128'(0));
    check("abort_resData", resData, 128'(0));
    check("abort_operands", dataToOperate | keyToOperate, 128'(0));
    RST = 1'b0; req0 = 1'b0;
    repeat (30) @(negedge CLK);

    // stats traffic: three results for requester 0, two for requester 1
    for (int i = 0; i < 5; i++) begin
      logic id;
      id = (i >= 3);
      expectOp(id, mkData(50 + i), mkKey(50 + i), coreFn(mkData(50 + i), mkKey(50 + i)));
      request(id, mkData(50 + i), mkKey(50 + i));
      drain();
    end
`ifdef AES128_ARB_STATS_EN
    check("opCount0", 128'(opCount0), 128'(3));
    check("opCount1", 128'(opCount1), 128'(2));
`endif
    check("ackQ_empty", 128'(ackQ.size()), 128'(0));
    check("resQ_empty", 128'(resQ.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
